// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pins: one requester at a time drives or samples the bus,
// with idle turnaround cycles on direction changes and a forced release after MAX_HOLD cycles.
module uio_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16,
    parameter int TURN     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    wr,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic [NREQ-1:0]    done,
    input  logic [DW-1:0]      uio_in,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      rdata,
    output logic               rvalid,
    output logic [DW-1:0]      uio_out,
    output logic [DW-1:0]      uio_oe,
    output logic               busy,
    output logic               timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TURN + 1);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_OWN
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic            dir_q;
    logic [TW-1:0]   tcnt;
    logic [HW-1:0]   hcnt;
    logic            drive;

    // Scan downwards so the candidate closest after the last owner is the one left in winner.
    always_comb begin
        winner = last;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            last    <= IW'(NREQ - 1);
            owner   <= '0;
            dir_q   <= 1'b0;
            tcnt    <= '0;
            hcnt    <= '0;
            gnt     <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ena && |req) begin
                        owner <= winner;
                        if (wr[winner] == dir_q) begin
                            state  <= ST_OWN;
                            hcnt   <= HW'(1);
                            gnt    <= NREQ'(1) << winner;
                            rvalid <= 1'b0;
                        end else begin
                            state <= ST_TURN;
                            tcnt  <= TW'(TURN - 1);
                        end
                    end
                end
                // Only a direction change gets here, so the new direction is simply the opposite one.
                ST_TURN: begin
                    if (!req[owner]) begin
                        state <= ST_IDLE;
                    end else if (tcnt == '0) begin
                        state  <= ST_OWN;
                        dir_q  <= ~dir_q;
                        hcnt   <= HW'(1);
                        gnt    <= NREQ'(1) << owner;
                        rvalid <= 1'b0;
                    end else begin
                        tcnt <= tcnt - 1'b1;
                    end
                end
                ST_OWN: begin
                    if (!dir_q) begin
                        rdata <= uio_in;
                    end
                    if (done[owner] || !req[owner] || hcnt == HW'(MAX_HOLD)) begin
                        state   <= ST_IDLE;
                        gnt     <= '0;
                        rvalid  <= 1'b0;
                        last    <= owner;
                        timeout <= !done[owner] && req[owner];
                    end else begin
                        hcnt   <= hcnt + 1'b1;
                        rvalid <= ~dir_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign drive   = (state == ST_OWN) && dir_q;
    assign uio_oe  = {DW{drive}};
    assign uio_out = drive ? wdata[int'(owner)*DW +: DW] : '0;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios with literal expectations plus a randomized
// phase, all cross-checked every cycle against a transaction-level model of the arbiter.
module tb_uio_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 16;
    localparam int TURN     = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   wr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   done;
    logic [DW-1:0]     uio_in;
    logic [NREQ-1:0]   gnt;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic [DW-1:0]     uio_out;
    logic [DW-1:0]     uio_oe;
    logic              busy;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    uio_bus_arbiter #(
        .NREQ(NREQ), .DW(DW), .MAX_HOLD(MAX_HOLD), .TURN(TURN)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .wr(wr), .wdata(wdata),
        .done(done), .uio_in(uio_in), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
        .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Transaction-level view: who owns the bus, who is waiting out a turnaround, and for how long.
    int       m_owner = -1;
    int       m_pend  = -1;
    int       m_turn  = 0;
    int       m_hold  = 0;
    int       m_ptr   = NREQ - 1;
    bit       m_dir   = 1'b0;
    bit       m_pdir  = 1'b0;
    bit       m_to    = 1'b0;
    bit       m_rv    = 1'b0;
    bit       m_valid = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge clk) begin : model
        int w;
        if (rst) begin
            m_owner = -1; m_pend = -1; m_turn = 0; m_hold = 0; m_ptr = NREQ - 1;
            m_dir = 1'b0; m_to = 1'b0; m_rv = 1'b0; m_rdata = '0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (!m_dir) m_rdata = uio_in;
                if (done[m_owner] || !req[m_owner] || m_hold == MAX_HOLD) begin
                    m_to    = !done[m_owner] && req[m_owner];
                    m_ptr   = m_owner;
                    m_owner = -1;
                    m_rv    = 1'b0;
                end else begin
                    m_hold = m_hold + 1;
                    m_rv   = !m_dir;
                end
            end else if (m_pend >= 0) begin
                if (!req[m_pend]) begin
                    m_pend = -1;
                end else if (m_turn == 1) begin
                    m_dir   = m_pdir;
                    m_owner = m_pend;
                    m_pend  = -1;
                    m_hold  = 1;
                    m_rv    = 1'b0;
                end else begin
                    m_turn = m_turn - 1;
                end
            end else if (ena && req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                if (wr[w] == m_dir) begin
                    m_owner = w; m_hold = 1; m_rv = 1'b0;
                end else begin
                    m_pend = w; m_turn = TURN; m_pdir = wr[w];
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [NREQ-1:0] eg;
        logic [DW-1:0]   eoe;
        logic [DW-1:0]   eout;
        if (!m_valid) return;
        eg   = '0;
        eoe  = '0;
        eout = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            if (m_dir) begin
                eoe  = '1;
                eout = wdata[m_owner*DW +: DW];
            end
        end
        cmp("m_gnt", 32'(gnt), 32'(eg));
        cmp("m_uio_oe", 32'(uio_oe), 32'(eoe));
        cmp("m_uio_out", 32'(uio_out), 32'(eout));
        cmp("m_busy", 32'(busy), 32'(m_owner >= 0 || m_pend >= 0));
        cmp("m_timeout", 32'(timeout), 32'(m_to));
        cmp("m_rvalid", 32'(rvalid), 32'(m_rv));
        if (m_rv) cmp("m_rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                                 input logic [NREQ-1:0] d, input logic e);
        req  = r;
        wr   = w;
        done = d;
        ena  = e;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] fair_exp [9];
        int  cnt;
        bit  seen;
        fair_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

        rst = 1'b1; uio_in = 8'h3C; wdata = '0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        step();
        cmp("rst_gnt", 32'(gnt), 0);
        cmp("rst_oe", 32'(uio_oe), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_rvalid", 32'(rvalid), 0);
        cmp("rst_rdata", 32'(rdata), 0);
        cmp("rst_timeout", 32'(timeout), 0);

        // Read grant, rvalid on second cycle, then done hands over to requester 2.
        rst = 1'b0;
        applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b1);
        step();
        cmp("t1_gnt", 32'(gnt), 32'h1);
        cmp("t1_oe", 32'(uio_oe), 0);
        cmp("t1_rvalid_first", 32'(rvalid), 0);
        step();
        cmp("t1_rvalid_second", 32'(rvalid), 1);
        cmp("t1_rdata", 32'(rdata), 32'h3C);
        applyStimulus(4'b0101, 4'b0000, 4'b0001, 1'b1);
        step();
        cmp("t1_release_gnt", 32'(gnt), 0);
        applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b1);
        step();
        cmp("t1_next_gnt", 32'(gnt), 32'h4);

        // Read to write: one turnaround cycle with the pins released.
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        step();
        wdata = 32'h0000_A500;
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1);
        step();
        cmp("t2_turn_gnt", 32'(gnt), 0);
        cmp("t2_turn_oe", 32'(uio_oe), 0);
        cmp("t2_turn_busy", 32'(busy), 1);
        step();
        cmp("t2_own_gnt", 32'(gnt), 32'h2);
        cmp("t2_own_oe", 32'(uio_oe), 32'hFF);
        cmp("t2_own_out", 32'(uio_out), 32'hA5);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        step();

        // Fairness from reset with every requester asking.
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step();
            cmp($sformatf("t3_order_%0d", i), 32'(gnt), 32'(fair_exp[i]));
            done = gnt;
        end

        // Forced release after MAX_HOLD cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(4'b1100, 4'b0000, 4'b0000, 1'b1);
        cnt  = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (gnt == 4'b0100) cnt++;
            else if (cnt > 0) seen = 1'b1;
        end
        cmp("t4_hold_len", 32'(cnt), MAX_HOLD);
        cmp("t4_timeout_pulse", 32'(timeout), 1);
        step();
        cmp("t4_next_gnt", 32'(gnt), 32'h8);
        cmp("t4_timeout_clear", 32'(timeout), 0);

        // Reset while a write owner drives the pins.
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        step();
        wdata = 32'h0000_00C3;
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
        step();
        step();
        cmp("t5_own_oe", 32'(uio_oe), 32'hFF);
        cmp("t5_own_out", 32'(uio_out), 32'hC3);
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1);
        step();
        cmp("t5_rst_gnt", 32'(gnt), 0);
        cmp("t5_rst_oe", 32'(uio_oe), 0);
        cmp("t5_rst_busy", 32'(busy), 0);
        cmp("t5_rst_timeout", 32'(timeout), 0);
        rst = 1'b0;
        step();
        cmp("t5_after_gnt", 32'(gnt), 32'h1);

        // ena gates new grants only.
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        step();
        applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b0);
        step();
        cmp("t6_ena0_gnt_a", 32'(gnt), 0);
        step();
        cmp("t6_ena0_gnt_b", 32'(gnt), 0);
        cmp("t6_ena0_busy", 32'(busy), 0);
        ena = 1'b1;
        step();
        cmp("t6_ena1_gnt", 32'(gnt), 32'h8);

        // Randomized traffic: sticky requests, sparse done strobes, rare resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(99) < 8) req[i] = ~req[i];
                if ($urandom_range(99) < 20) wr[i] = ~wr[i];
            end
            done   = ($urandom_range(99) < 6) ? NREQ'($urandom_range(15)) : '0;
            ena    = ($urandom_range(99) < 90);
            rst    = ($urandom_range(999) < 3);
            wdata  = $urandom;
            uio_in = DW'($urandom);
            step();
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
